// File: rtl/uart_wb_bridge_pkg.sv
// -----------------------------------------------------------------------------
// uart_wb_bridge_pkg
// Shared constants and types for the UART16550 Wishbone bridge:
//   - UART register offsets (8-bit bus mode, byte addresses 0..7)
//   - LSR bit positions used by the bridge
//   - DLAB mask for LCR
//   - Top-level FSM state encoding and a helper to classify init states
// -----------------------------------------------------------------------------
package uart_wb_bridge_pkg;

    // Register offsets. DLL/DLM alias RBR_THR/IER while LCR.DLAB=1.
    localparam logic [2:0] REG_RBR_THR = 3'd0;
    localparam logic [2:0] REG_DLL     = 3'd0;
    localparam logic [2:0] REG_IER     = 3'd1;
    localparam logic [2:0] REG_DLM     = 3'd1;
    localparam logic [2:0] REG_FCR     = 3'd2;
    localparam logic [2:0] REG_LCR     = 3'd3;
    localparam logic [2:0] REG_LSR     = 3'd5;

    // Line status register bits.
    localparam int LSR_DR   = 0;
    localparam int LSR_OE   = 1;
    localparam int LSR_THRE = 5;

    localparam logic [7:0] DLAB_MASK = 8'h80;

    typedef enum logic [3:0] {
        INIT_LCR_DLAB = 4'd0,
        INIT_DLL      = 4'd1,
        INIT_DLM      = 4'd2,
        INIT_LCR      = 4'd3,
        INIT_FCR      = 4'd4,
        IDLE          = 4'd5,
        RD_LSR        = 4'd6,
        RD_RBR        = 4'd7,
        WR_THR        = 4'd8
    } state_t;

    function automatic logic is_init_state(state_t s);
        return s inside {INIT_LCR_DLAB, INIT_DLL, INIT_DLM, INIT_LCR, INIT_FCR};
    endfunction

endpackage

// File: rtl/uart_wb_bridge_if.sv
// -----------------------------------------------------------------------------
// uart_wb_bridge_if
// Wishbone link between the bridge (master) and a UART16550 core in 8-bit
// bus mode (slave). Signal names are from the bridge's point of view.
//   wb_adr_o [2:0]  register address          master -> slave
//   wb_dat_o [7:0]  write data                master -> slave
//   wb_dat_i [7:0]  read data                 slave  -> master
//   wb_cyc_o        bus cycle                 master -> slave
//   wb_stb_o        strobe (equal to cyc)     master -> slave
//   wb_we_o         write enable              master -> slave
//   wb_ack_i        cycle acknowledge         slave  -> master
// -----------------------------------------------------------------------------
interface uart_wb_bridge_if;

    logic [2:0] wb_adr_o;
    logic [7:0] wb_dat_o;
    logic [7:0] wb_dat_i;
    logic       wb_cyc_o;
    logic       wb_stb_o;
    logic       wb_we_o;
    logic       wb_ack_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_cyc_o, wb_stb_o, wb_we_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_cyc_o, wb_stb_o, wb_we_o,
        output wb_dat_i, wb_ack_i
    );

endinterface

// File: rtl/uart_wb_bridge_cycle.sv
// -----------------------------------------------------------------------------
// uart_wb_bridge_cycle
// Single Wishbone read/write cycle engine. When idle and req=1, it latches
// we/adr/wdat and raises cyc/stb on the next edge, holding everything until
// the first cycle with ack=1. cyc drops on the ack edge, so at least one idle
// cycle always separates two accesses.
//   wb_clk_i, wb_rst_i  clock, synchronous active-low reset
//   req, we, adr, wdat  access request (must stay stable until done/timeout)
//   done                1 in the ack cycle (cyc && ack)
//   timeout             1 in the cycle the ack wait is abandoned
//   rdata               slave read data, valid while done=1
//   wb                  Wishbone master port
// Optional: UART_BRIDGE_TIMEOUT_EN adds an ack-wait counter (TIMEOUT cycles);
// without it timeout is tied 0 and the engine waits for ack forever.
// -----------------------------------------------------------------------------
module uart_wb_bridge_cycle
`ifdef UART_BRIDGE_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT = 16
)
`endif
(
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             req,
    input  logic             we,
    input  logic [2:0]       adr,
    input  logic [7:0]       wdat,
    output logic             done,
    output logic             timeout,
    output logic [7:0]       rdata,
    uart_wb_bridge_if.master wb
);

    logic cyc;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            cyc         <= 1'b0;
            wb.wb_adr_o <= '0;
            wb.wb_dat_o <= '0;
            wb.wb_we_o  <= 1'b0;
        end else if (!cyc) begin
            if (req) begin
                cyc         <= 1'b1;
                wb.wb_adr_o <= adr;
                wb.wb_dat_o <= wdat;
                wb.wb_we_o  <= we;
            end
        end else if (wb.wb_ack_i || timeout) begin
            cyc <= 1'b0;
        end
    end

    assign wb.wb_cyc_o = cyc;
    assign wb.wb_stb_o = cyc;
    assign done        = cyc && wb.wb_ack_i;
    // Passed straight through so the sequencer can act on it at the ack edge.
    assign rdata       = wb.wb_dat_i;

`ifdef UART_BRIDGE_TIMEOUT_EN
    logic [15:0] wait_cnt;

    // Counts ack-less cycles of the current access; restarts at 0 per access.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i || !cyc) begin
            wait_cnt <= '0;
        end else if (!wb.wb_ack_i) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    // Fires in the TIMEOUT-th ack-less cycle, so cyc is high exactly TIMEOUT cycles.
    assign timeout = cyc && !wb.wb_ack_i && (wait_cnt == 16'(TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: rtl/uart_wb_bridge.sv
// -----------------------------------------------------------------------------
// uart_wb_bridge
// Wishbone master in front of a UART16550 (8-bit bus). After reset it writes
// LCR(DLAB) -> DLL -> DLM -> LCR -> FCR, then polls LSR and moves bytes
// between the valid/ready streams and RBR/THR through one-byte holding
// registers. RX is served before TX on each LSR poll.
//   wb_clk_i, wb_rst_i            clock, synchronous active-low reset
//   wb                            Wishbone master port to the UART
//   tx_data_i/tx_valid_i/tx_ready_o  byte stream into the UART
//   rx_data_o/rx_valid_o/rx_ready_i  byte stream out of the UART
//   init_done_o                   init sequence finished
//   rx_overrun_o                  sticky, LSR.OE observed
//   bus_err_o                     sticky, ack timeout (0 without the option)
// Optional: UART_BRIDGE_TIMEOUT_EN enables the ack timeout (parameter TIMEOUT).
// -----------------------------------------------------------------------------
module uart_wb_bridge
    import uart_wb_bridge_pkg::*;
#(
    parameter logic [15:0] DIVISOR = 16'd27,
    parameter logic [7:0]  LCR_VAL = 8'h03,
    parameter logic [7:0]  FCR_VAL = 8'h07
`ifdef UART_BRIDGE_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 16
`endif
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    uart_wb_bridge_if.master wb,
    input  logic [7:0]       tx_data_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    output logic [7:0]       rx_data_o,
    output logic             rx_valid_o,
    input  logic             rx_ready_i,
    output logic             init_done_o,
    output logic             rx_overrun_o,
    output logic             bus_err_o
);

    state_t     state, next_state;
    logic       req, we, done, timeout;
    logic [2:0] adr;
    logic [7:0] wdat, rdata;
    logic       tx_full;
    logic [7:0] tx_buf;

    uart_wb_bridge_cycle
`ifdef UART_BRIDGE_TIMEOUT_EN
        #(.TIMEOUT(TIMEOUT))
`endif
        u_cycle (
            .wb_clk_i (wb_clk_i),
            .wb_rst_i (wb_rst_i),
            .req      (req),
            .we       (we),
            .adr      (adr),
            .wdat     (wdat),
            .done     (done),
            .timeout  (timeout),
            .rdata    (rdata),
            .wb       (wb)
        );

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) state <= INIT_LCR_DLAB;
        else           state <= next_state;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        next_state = state;
        req        = 1'b0;
        we         = 1'b0;
        adr        = REG_RBR_THR;
        wdat       = '0;
        unique case (state)
            INIT_LCR_DLAB: begin
                req = 1'b1; we = 1'b1; adr = REG_LCR; wdat = LCR_VAL | DLAB_MASK;
                if (done) next_state = INIT_DLL;
            end
            INIT_DLL: begin
                req = 1'b1; we = 1'b1; adr = REG_DLL; wdat = DIVISOR[7:0];
                if (done) next_state = INIT_DLM;
            end
            INIT_DLM: begin
                req = 1'b1; we = 1'b1; adr = REG_DLM; wdat = DIVISOR[15:8];
                if (done) next_state = INIT_LCR;
            end
            INIT_LCR: begin
                // Clears DLAB, so THR is reachable from here on.
                req = 1'b1; we = 1'b1; adr = REG_LCR; wdat = LCR_VAL;
                if (done) next_state = INIT_FCR;
            end
            INIT_FCR: begin
                req = 1'b1; we = 1'b1; adr = REG_FCR; wdat = FCR_VAL;
                if (done) next_state = IDLE;
            end
            IDLE: begin
                // Nothing to do only when TX is empty and RX is already full.
                if (tx_full || !rx_valid_o) next_state = RD_LSR;
            end
            RD_LSR: begin
                req = 1'b1; adr = REG_LSR;
                if (done) begin
                    if (rdata[LSR_DR] && !rx_valid_o)     next_state = RD_RBR;
                    else if (rdata[LSR_THRE] && tx_full)  next_state = WR_THR;
                    else                                  next_state = IDLE;
                end
            end
            RD_RBR: begin
                req = 1'b1; adr = REG_RBR_THR;
                if (done) next_state = IDLE;
            end
            WR_THR: begin
                req = 1'b1; we = 1'b1; adr = REG_RBR_THR; wdat = tx_buf;
                if (done) next_state = IDLE;
            end
            default: next_state = INIT_LCR_DLAB;
        endcase
        // An abandoned init write leaves the UART half-programmed: redo it all.
        if (timeout) next_state = is_init_state(state) ? INIT_LCR_DLAB : IDLE;
    end

    assign tx_ready_o = init_done_o && !tx_full;

    // Fill and drain of a holding register are mutually exclusive: fill needs
    // it empty, drain needs it full.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            tx_full      <= 1'b0;
            tx_buf       <= '0;
            rx_valid_o   <= 1'b0;
            rx_data_o    <= '0;
            init_done_o  <= 1'b0;
            rx_overrun_o <= 1'b0;
        end else begin
            if (tx_valid_i && tx_ready_o) begin
                tx_full <= 1'b1;
                tx_buf  <= tx_data_i;
            end else if (state == WR_THR && done) begin
                tx_full <= 1'b0;
            end

            if (state == RD_RBR && done) begin
                rx_valid_o <= 1'b1;
                rx_data_o  <= rdata;
            end else if (rx_valid_o && rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end

            if (state == INIT_FCR && done) init_done_o <= 1'b1;
            if (state == RD_LSR && done && rdata[LSR_OE]) rx_overrun_o <= 1'b1;
        end
    end

`ifdef UART_BRIDGE_TIMEOUT_EN
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i)    bus_err_o <= 1'b0;
        else if (timeout) bus_err_o <= 1'b1;
    end
`else
    assign bus_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_wb_bridge.sv
// -----------------------------------------------------------------------------
// tb_uart_wb_bridge
// Directed bench for uart_wb_bridge with a scripted UART slave: acks every
// access one cycle after cyc rises, answers LSR reads from a queue (falling
// back to a default) and RBR reads from a fixed byte, and logs each completed
// access as {we, adr, dat}.
// -----------------------------------------------------------------------------
module tb_uart_wb_bridge;

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic       init_done_o;
    logic       rx_overrun_o;
    logic       bus_err_o;

    always #5 wb_clk_i = ~wb_clk_i;

    uart_wb_bridge_if wb ();

    uart_wb_bridge #(
        .DIVISOR (16'h0102),
        .LCR_VAL (8'h03),
        .FCR_VAL (8'h07)
`ifdef UART_BRIDGE_TIMEOUT_EN
        ,
        .TIMEOUT (16)
`endif
    ) dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_i     (wb_rst_i),
        .wb           (wb),
        .tx_data_i    (tx_data_i),
        .tx_valid_i   (tx_valid_i),
        .tx_ready_o   (tx_ready_o),
        .rx_data_o    (rx_data_o),
        .rx_valid_o   (rx_valid_o),
        .rx_ready_i   (rx_ready_i),
        .init_done_o  (init_done_o),
        .rx_overrun_o (rx_overrun_o),
        .bus_err_o    (bus_err_o)
    );

    int          tests = 0;
    int          fails = 0;
    logic [11:0] log_q [$];
    logic [7:0]  lsr_q [$];
    logic [7:0]  lsr_default;
    logic [7:0]  rbr_val;
    logic [7:0]  slave_rd;
    bit          no_ack;
    bit          stb_bad = 1'b0;

    // Slave model, acting on the falling edge.
    always @(negedge wb_clk_i) begin
        if (wb.wb_cyc_o !== wb.wb_stb_o) stb_bad = 1'b1;
        if (wb.wb_cyc_o && wb.wb_stb_o && !wb.wb_ack_i && !no_ack) begin
            if (wb.wb_we_o) begin
                wb.wb_dat_i = 8'h00;
                log_q.push_back({1'b1, wb.wb_adr_o, wb.wb_dat_o});
            end else begin
                if (wb.wb_adr_o == 3'd5) slave_rd = (lsr_q.size() > 0) ? lsr_q.pop_front() : lsr_default;
                else                     slave_rd = rbr_val;
                wb.wb_dat_i = slave_rd;
                log_q.push_back({1'b0, wb.wb_adr_o, slave_rd});
            end
            wb.wb_ack_i = 1'b1;
        end else begin
            wb.wb_ack_i = 1'b0;
            wb.wb_dat_i = 8'h00;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #2;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_init(input string tag);
        int n = 0;
        while (!init_done_o && n < 300) begin tick(); n++; end
        check(tag, init_done_o, 1);
    endtask

    task automatic send_byte(input string tag, input logic [7:0] b);
        int n = 0;
        tx_data_i  = b;
        tx_valid_i = 1'b1;
        while (!tx_ready_o && n < 200) begin tick(); n++; end
        check(tag, tx_ready_o, 1);
        tick();
        tx_valid_i = 1'b0;
    endtask

    function automatic logic [11:0] log_at(input int i);
        return (i < log_q.size()) ? log_q[i] : 12'hFFF;
    endfunction

    function automatic int first_write();
        foreach (log_q[i]) if (log_q[i][11]) return i;
        return -1;
    endfunction

    function automatic int count_writes();
        int c = 0;
        foreach (log_q[i]) if (log_q[i][11]) c++;
        return c;
    endfunction

    function automatic int count_rbr_reads();
        int c = 0;
        foreach (log_q[i]) if (!log_q[i][11] && log_q[i][10:8] == 3'd0) c++;
        return c;
    endfunction

    initial begin
        logic [11:0] init_exp [5];
        int          n;
        bit          early, stable;
        init_exp = '{12'hB83, 12'h802, 12'h901, 12'hB03, 12'hA07};

        wb_rst_i    = 1'b0;
        tx_data_i   = 8'h00;
        tx_valid_i  = 1'b0;
        rx_ready_i  = 1'b0;
        lsr_default = 8'h00;
        rbr_val     = 8'h00;
        no_ack      = 1'b0;
        ticks(3);

        // Reset state.
        check("rst_cyc",      wb.wb_cyc_o, 0);
        check("rst_stb",      wb.wb_stb_o, 0);
        check("rst_adr",      wb.wb_adr_o, 0);
        check("rst_dat",      wb.wb_dat_o, 0);
        check("rst_we",       wb.wb_we_o, 0);
        check("rst_tx_ready", tx_ready_o, 0);
        check("rst_rx_valid", rx_valid_o, 0);
        check("rst_rx_data",  rx_data_o, 0);
        check("rst_init",     init_done_o, 0);
        check("rst_overrun",  rx_overrun_o, 0);
        check("rst_bus_err",  bus_err_o, 0);

`ifdef UART_BRIDGE_TIMEOUT_EN
        // Slave never acks: cycle abandoned after 16 cycles, init retried.
        no_ack   = 1'b1;
        wb_rst_i = 1'b1;
        n = 0;
        while (!wb.wb_cyc_o && n < 20) begin tick(); n++; end
        check("to_cyc_start", wb.wb_cyc_o, 1);
        n = 0;
        while (wb.wb_cyc_o && n < 100) begin n++; tick(); end
        check("to_cyc_len", n, 16);
        check("to_bus_err", bus_err_o, 1);
        check("to_init_done", init_done_o, 0);
        n = 0;
        while (!wb.wb_cyc_o && n < 20) begin tick(); n++; end
        check("to_retry_adr", wb.wb_adr_o, 3);
        check("to_retry_dat", wb.wb_dat_o, 8'h83);
        ticks(20);
        check("to_bus_err_sticky", bus_err_o, 1);
        wb_rst_i = 1'b0;
        ticks(2);
        check("to_bus_err_rst", bus_err_o, 0);
        no_ack = 1'b0;
`endif

        // Init sequence.
        log_q.delete();
        wb_rst_i = 1'b1;
        wait_init("init_done");
        for (int i = 0; i < 5; i++) check($sformatf("init_wr%0d", i), log_at(i), init_exp[i]);
        check("init_tx_ready", tx_ready_o, 1);

        // TX with THRE set: single THR write, ready low until its ack.
        lsr_default = 8'h60;
        ticks(4);
        log_q.delete();
        tx_data_i  = 8'h55;
        tx_valid_i = 1'b1;
        check("tx_ready_pre", tx_ready_o, 1);
        tick();
        tx_valid_i = 1'b0;
        check("tx_ready_accepted", tx_ready_o, 0);
        early = 1'b0;
        n = 0;
        while (count_writes() == 0 && n < 100) begin
            if (tx_ready_o) early = 1'b1;
            tick();
            n++;
        end
        check("tx_ready_early", early, 0);
        check("tx_ready_after_ack", tx_ready_o, 1);
        ticks(20);
        check("tx_write_count", count_writes(), 1);
        check("tx_write_val", log_at(first_write()), 12'h855);

        // THRE clear for 10 polls: byte held until the 11th poll.
        lsr_default = 8'h00;
        ticks(4);
        send_byte("busy_accept", 8'hC3);
        log_q.delete();
        repeat (10) lsr_q.push_back(8'h00);
        lsr_q.push_back(8'h20);
        n = 0;
        while (count_writes() == 0 && n < 300) begin tick(); n++; end
        check("busy_polls", first_write(), 11);
        check("busy_write_val", log_at(first_write()), 12'h8C3);
        check("busy_queue_used", lsr_q.size(), 0);

        // RX: byte held while the consumer stalls, no further RBR reads.
        lsr_default = 8'h01;
        rbr_val     = 8'hA5;
        log_q.delete();
        n = 0;
        while (!rx_valid_o && n < 100) begin tick(); n++; end
        check("rx_valid", rx_valid_o, 1);
        check("rx_data", rx_data_o, 8'hA5);
        stable = 1'b1;
        repeat (20) begin
            tick();
            if (!rx_valid_o || rx_data_o != 8'hA5) stable = 1'b0;
        end
        check("rx_stable", stable, 1);
        check("rx_rbr_reads", count_rbr_reads(), 1);
        check("rx_log_len", log_q.size(), 2);
        lsr_default = 8'h00;
        rx_ready_i  = 1'b1;
        tick();
        rx_ready_i = 1'b0;
        check("rx_consumed", rx_valid_o, 0);
        check("rx_no_overrun", rx_overrun_o, 0);

        // LSR=0x23 with TX pending: RBR first, new poll, then THR.
        send_byte("prio_accept", 8'h3C);
        log_q.delete();
        rbr_val     = 8'h5A;
        lsr_default = 8'h23;
        ticks(40);
        lsr_default = 8'h00;
        check("prio_log_len", log_q.size(), 4);
        check("prio_0_lsr", log_at(0), 12'h523);
        check("prio_1_rbr", log_at(1), 12'h05A);
        check("prio_2_lsr", log_at(2), 12'h523);
        check("prio_3_thr", log_at(3), 12'h83C);
        check("prio_rx_data", rx_data_o, 8'h5A);
        check("prio_overrun", rx_overrun_o, 1);
        rx_ready_i = 1'b1;
        tick();
        rx_ready_i = 1'b0;
        ticks(10);
        check("overrun_sticky", rx_overrun_o, 1);

        // Reset while a cycle waits for ack.
        no_ack = 1'b1;
        n = 0;
        while (!wb.wb_cyc_o && n < 20) begin tick(); n++; end
        check("midrst_cyc_before", wb.wb_cyc_o, 1);
        wb_rst_i = 1'b0;
        tick();
        check("midrst_cyc", wb.wb_cyc_o, 0);
        check("midrst_stb", wb.wb_stb_o, 0);
        check("midrst_init", init_done_o, 0);
        check("midrst_overrun", rx_overrun_o, 0);
        check("midrst_tx_ready", tx_ready_o, 0);
        no_ack = 1'b0;
        log_q.delete();
        wb_rst_i = 1'b1;
        wait_init("midrst_reinit");
        check("midrst_first_wr", log_at(0), 12'hB83);
        check("midrst_last_wr", log_at(4), 12'hA07);

        check("cyc_eq_stb", stb_bad, 0);
`ifndef UART_BRIDGE_TIMEOUT_EN
        check("bus_err_tied", bus_err_o, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
